rice_csr_access_sequencer: RTL and testbench
============================================

// Module: rice_csr_access_sequencer
// PURPOSE
//   Sits between the core's CSR execute stage and the rggen CSR register block. Turns one
//   CSRRW/CSRRS/CSRRC request into a sequence of rggen bus transactions:
//     read -> modify -> write.
//   It returns the old CSR value to the pipeline. It skips the read or the write exactly as
//   the RISC-V rules require (rd=x0 / rs1=x0).
// PARAMETERS
//   XLEN           32  CSR/bus data width (32 or 64)
//   ADDRESS_WIDTH  12  CSR number width
//   BUS_ADDR_WIDTH ADDRESS_WIDTH+$clog2(XLEN/8)  byte address width on the rggen bus (derived)
// PORTS
//   i_clk            in   1               clock
//   i_rst_n          in   1               asynchronous active-low reset
//   i_req_valid      in   1               CSR request valid
//   o_req_ready      out  1               request accepted when valid&&ready
//   i_req_op         in   2               01=RW 10=RS 11=RC 00=illegal
//   i_req_address    in   ADDRESS_WIDTH   CSR number
//   i_req_data       in   XLEN            rs1/uimm operand
//   i_req_no_read    in   1               rd==x0 (honoured for RW only)
//   i_req_no_write   in   1               rs1/uimm==0 (honoured for RS/RC only)
//   o_resp_valid     out  1               response valid, held until i_resp_ready
//   i_resp_ready     in   1               response consumed
//   o_resp_data      out  XLEN            old CSR value (0 if read skipped)
//   o_resp_error     out  1               access failed
//   o_bus_valid      out  1               rggen bus request valid
//   i_bus_ready      in   1               rggen bus request complete
//   o_bus_access     out  rggen_access    RGGEN_READ or RGGEN_WRITE (never POSTED)
//   o_bus_address    out  BUS_ADDR_WIDTH  {csr_number, zeros}
//   o_bus_write_data out  XLEN            write data
//   o_bus_strobe     out  XLEN/8          all ones for writes, '0 for reads
//   i_bus_status     in   rggen_status    completion status
//   i_bus_read_data  in   XLEN            read data
// BEHAVIOUR
//   - FSM IDLE/READ/WRITE/RESP; all outputs registered.
//   - Reset: state=IDLE, o_req_ready=1, o_bus_valid=0, o_resp_valid=0, o_resp_error=0,
//     data/address regs=0.
//   - o_req_ready=1 only in IDLE. Accept latches op/address/data/no_read/no_write.
//   - Leaving IDLE on accept:
//       op 00 -> RESP;
//       RW with no_read -> WRITE;
//       otherwise -> READ.
//   - READ: o_bus_valid=1, access=RGGEN_READ. On i_bus_ready, capture i_bus_read_data into
//     the old-value register, then go to:
//       RESP if RS/RC with no_write, or if errored (see macro);
//       WRITE otherwise.
//   - WRITE data: RW=operand; RS=old|operand; RC=old&~operand. Computed at READ completion,
//     at full XLEN width.
//   - WRITE: o_bus_valid=1, access=RGGEN_WRITE. On i_bus_ready go to RESP.
//   - Bus rule: while o_bus_valid=1, access/address/data/strobe are stable; valid never
//     drops before ready.
//   - RESP: o_resp_valid=1, data stable. On i_resp_ready go to IDLE. o_req_ready rises the
//     following cycle (no same-cycle back-to-back).
//   - Minimum latency, request accept to o_resp_valid (bus ready in the same cycle):
//       3 cycles for RMW; 2 cycles for a single access; 1 cycle for op 00.
//   - A READ completion with status not OKAY/EXOKAY may be flagged (see macro).
//     i_bus_ready together with o_resp stall has no effect outside READ/WRITE.
//   - Asynchronous reset mid-operation: o_bus_valid drops immediately. No response is issued
//     for the aborted request.
// CONFIGURATION
//   RICE_CSR_ACCESS_ERROR_EN defined:
//     - READ with error status -> skip WRITE, o_resp_error=1, o_resp_data=0.
//     - WRITE error status -> o_resp_error=1.
//     - op 00 -> o_resp_error=1.
//   RICE_CSR_ACCESS_ERROR_EN undefined:
//     - o_resp_error tied 0 and i_bus_status ignored; the write always follows the read.
//     - op 00 still performs no bus access; response data=0.
// TESTING
//   - RS addr 0x300, operand 0x8, bus read 0x1800 OKAY:
//       READ to 0xC00, then WRITE 0x1808; resp data 0x1800, error 0.
//   - RC operand 0x1800 on old 0x1808 -> write 0x0008. RW with no_read=1, operand 0xA5:
//       only WRITE 0xA5; resp data 0.
//   - RS no_write=1 -> single READ, no WRITE issued.
//   - i_bus_ready held low 5 cycles:
//       valid/address/data stable; o_req_ready stays 0.
//   - With ERROR_EN, read status SLAVE_ERROR -> no WRITE, resp error 1.
//     Without ERROR_EN -> WRITE issued, error 0.
//   - Reset asserted while in WRITE:
//       o_bus_valid=0 at once; IDLE with o_req_ready=1 after release.
//     Also: i_resp_ready low 4 cycles -> response held, no new accept.

Source files
------------

// File: rtl/rice_csr_access_sequencer.sv
// rice_csr_access_sequencer: CSRRW/CSRRS/CSRRC to rggen read-modify-write sequencer.
// Define RICE_CSR_ACCESS_ERROR_EN to report bus-status and illegal-op errors.
package rggen_rtl_pkg;
    typedef enum logic [1:0] {
        RGGEN_POSTED_WRITE = 2'b01,
        RGGEN_READ         = 2'b10,
        RGGEN_WRITE        = 2'b11
    } rggen_access;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;
endpackage

module rice_csr_access_sequencer
    import rggen_rtl_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDRESS_WIDTH  = 12,
    parameter int BUS_ADDR_WIDTH = ADDRESS_WIDTH + $clog2(XLEN / 8)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic [1:0]                i_req_op,
    input  logic [ADDRESS_WIDTH-1:0]  i_req_address,
    input  logic [XLEN-1:0]           i_req_data,
    input  logic                      i_req_no_read,
    input  logic                      i_req_no_write,
    output logic                      o_resp_valid,
    input  logic                      i_resp_ready,
    output logic [XLEN-1:0]           o_resp_data,
    output logic                      o_resp_error,
    output logic                      o_bus_valid,
    input  logic                      i_bus_ready,
    output rggen_access               o_bus_access,
    output logic [BUS_ADDR_WIDTH-1:0] o_bus_address,
    output logic [XLEN-1:0]           o_bus_write_data,
    output logic [XLEN/8-1:0]         o_bus_strobe,
    input  rggen_status               i_bus_status,
    input  logic [XLEN-1:0]           i_bus_read_data
);
    localparam int OFFSET_WIDTH = BUS_ADDR_WIDTH - ADDRESS_WIDTH;
    localparam logic [1:0] OP_ILLEGAL = 2'b00;
    localparam logic [1:0] OP_RW      = 2'b01;
    localparam logic [1:0] OP_RS      = 2'b10;
    localparam logic [1:0] OP_RC      = 2'b11;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t                    state_q, state_n;
    logic [1:0]                op_q, op_n;
    logic [XLEN-1:0]           operand_q, operand_n;
    logic                      no_write_q, no_write_n;
    logic [XLEN-1:0]           old_q, old_n;
    logic                      req_ready_q, req_ready_n;
    logic                      bus_valid_q, bus_valid_n;
    rggen_access               bus_access_q, bus_access_n;
    logic [BUS_ADDR_WIDTH-1:0] bus_address_q, bus_address_n;
    logic [XLEN-1:0]           bus_write_data_q, bus_write_data_n;
    logic [XLEN/8-1:0]         bus_strobe_q, bus_strobe_n;
    logic                      resp_valid_q, resp_valid_n;
    logic [XLEN-1:0]           resp_data_q, resp_data_n;
    logic                      resp_error_q, resp_error_n;
    logic                      bus_error;
    logic                      illegal_error;
    logic [XLEN-1:0]           modified;

`ifdef RICE_CSR_ACCESS_ERROR_EN
    assign bus_error     = !(i_bus_status inside {RGGEN_OKAY, RGGEN_EXOKAY});
    assign illegal_error = 1'b1;
`else
    logic unused_status;
    assign unused_status = ^i_bus_status;
    assign bus_error     = 1'b0;
    assign illegal_error = 1'b0;
`endif

    always_comb begin
        modified = operand_q;
        case (op_q)
            OP_RS:   modified = i_bus_read_data | operand_q;
            OP_RC:   modified = i_bus_read_data & ~operand_q;
            default: modified = operand_q;
        endcase
    end

    always_comb begin
        state_n          = state_q;
        op_n             = op_q;
        operand_n        = operand_q;
        no_write_n       = no_write_q;
        old_n            = old_q;
        req_ready_n      = req_ready_q;
        bus_valid_n      = bus_valid_q;
        bus_access_n     = bus_access_q;
        bus_address_n    = bus_address_q;
        bus_write_data_n = bus_write_data_q;
        bus_strobe_n     = bus_strobe_q;
        resp_valid_n     = resp_valid_q;
        resp_data_n      = resp_data_q;
        resp_error_n     = resp_error_q;
        unique case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    op_n          = i_req_op;
                    operand_n     = i_req_data;
                    no_write_n    = i_req_no_write;
                    old_n         = '0;
                    req_ready_n   = 1'b0;
                    bus_address_n = {i_req_address, {OFFSET_WIDTH{1'b0}}};
                    if (i_req_op == OP_ILLEGAL) begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_data_n  = '0;
                        resp_error_n = illegal_error;
                    end else if (i_req_op == OP_RW && i_req_no_read) begin
                        state_n          = WRITE;
                        bus_valid_n      = 1'b1;
                        bus_access_n     = RGGEN_WRITE;
                        bus_write_data_n = i_req_data;
                        bus_strobe_n     = '1;
                    end else begin
                        state_n          = READ;
                        bus_valid_n      = 1'b1;
                        bus_access_n     = RGGEN_READ;
                        bus_write_data_n = '0;
                        bus_strobe_n     = '0;
                    end
                end
            end
            READ: begin
                if (i_bus_ready) begin
                    old_n = i_bus_read_data;
                    if (bus_error) begin
                        state_n      = RESP;
                        bus_valid_n  = 1'b0;
                        resp_valid_n = 1'b1;
                        resp_data_n  = '0;
                        resp_error_n = 1'b1;
                    end else if (op_q != OP_RW && no_write_q) begin
                        state_n      = RESP;
                        bus_valid_n  = 1'b0;
                        resp_valid_n = 1'b1;
                        resp_data_n  = i_bus_read_data;
                        resp_error_n = 1'b0;
                    end else begin
                        state_n          = WRITE;
                        bus_access_n     = RGGEN_WRITE;
                        bus_write_data_n = modified;
                        bus_strobe_n     = '1;
                    end
                end
            end
            WRITE: begin
                if (i_bus_ready) begin
                    state_n      = RESP;
                    bus_valid_n  = 1'b0;
                    resp_valid_n = 1'b1;
                    resp_data_n  = old_q;
                    resp_error_n = bus_error;
                end
            end
            RESP: begin
                if (i_resp_ready) begin
                    state_n      = IDLE;
                    resp_valid_n = 1'b0;
                    req_ready_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q          <= IDLE;
            op_q             <= OP_ILLEGAL;
            operand_q        <= '0;
            no_write_q       <= 1'b0;
            old_q            <= '0;
            req_ready_q      <= 1'b1;
            bus_valid_q      <= 1'b0;
            bus_access_q     <= RGGEN_READ;
            bus_address_q    <= '0;
            bus_write_data_q <= '0;
            bus_strobe_q     <= '0;
            resp_valid_q     <= 1'b0;
            resp_data_q      <= '0;
            resp_error_q     <= 1'b0;
        end else begin
            state_q          <= state_n;
            op_q             <= op_n;
            operand_q        <= operand_n;
            no_write_q       <= no_write_n;
            old_q            <= old_n;
            req_ready_q      <= req_ready_n;
            bus_valid_q      <= bus_valid_n;
            bus_access_q     <= bus_access_n;
            bus_address_q    <= bus_address_n;
            bus_write_data_q <= bus_write_data_n;
            bus_strobe_q     <= bus_strobe_n;
            resp_valid_q     <= resp_valid_n;
            resp_data_q      <= resp_data_n;
            resp_error_q     <= resp_error_n;
        end
    end

    assign o_req_ready      = req_ready_q;
    assign o_bus_valid      = bus_valid_q;
    assign o_bus_access     = bus_access_q;
    assign o_bus_address    = bus_address_q;
    assign o_bus_write_data = bus_write_data_q;
    assign o_bus_strobe     = bus_strobe_q;
    assign o_resp_valid     = resp_valid_q;
    assign o_resp_data      = resp_data_q;
    assign o_resp_error     = resp_error_q;
endmodule

// File: tb/tb_rice_csr_access_sequencer.sv
// Scoreboard bench for rice_csr_access_sequencer: rggen bus responder,
// bus/response monitors and directed CSR request vectors.
module tb_rice_csr_access_sequencer;
    import rggen_rtl_pkg::*;

    localparam int XLEN = 32;
    localparam int AW   = 12;
    localparam int BAW  = 14;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_req_valid;
    logic            o_req_ready;
    logic [1:0]      i_req_op;
    logic [AW-1:0]   i_req_address;
    logic [XLEN-1:0] i_req_data;
    logic            i_req_no_read;
    logic            i_req_no_write;
    logic            o_resp_valid;
    logic            i_resp_ready;
    logic [XLEN-1:0] o_resp_data;
    logic            o_resp_error;
    logic            o_bus_valid;
    logic            i_bus_ready;
    rggen_access     o_bus_access;
    logic [BAW-1:0]  o_bus_address;
    logic [XLEN-1:0] o_bus_write_data;
    logic [3:0]      o_bus_strobe;
    rggen_status     i_bus_status;
    logic [XLEN-1:0] i_bus_read_data;

    rice_csr_access_sequencer #(.XLEN(XLEN), .ADDRESS_WIDTH(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_op(i_req_op), .i_req_address(i_req_address),
        .i_req_data(i_req_data), .i_req_no_read(i_req_no_read),
        .i_req_no_write(i_req_no_write),
        .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_resp_data(o_resp_data), .o_resp_error(o_resp_error),
        .o_bus_valid(o_bus_valid), .i_bus_ready(i_bus_ready),
        .o_bus_access(o_bus_access), .o_bus_address(o_bus_address),
        .o_bus_write_data(o_bus_write_data), .o_bus_strobe(o_bus_strobe),
        .i_bus_status(i_bus_status), .i_bus_read_data(i_bus_read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            write;
        logic [BAW-1:0]  addr;
        logic [XLEN-1:0] data;
    } bus_exp_t;

    typedef struct {
        logic [XLEN-1:0] data;
        logic            error;
    } resp_exp_t;

    bus_exp_t  bus_q[$];
    resp_exp_t resp_q[$];
    int vectors = 0;
    int miscompares = 0;

    int              bus_delay = 0;
    logic [XLEN-1:0] bus_rdata = '0;
    rggen_status     bus_stat  = RGGEN_OKAY;

`ifdef RICE_CSR_ACCESS_ERROR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_bus(input logic wr, input logic [BAW-1:0] a,
                           input logic [XLEN-1:0] d);
        bus_exp_t e;
        e.write = wr;
        e.addr  = a;
        e.data  = d;
        bus_q.push_back(e);
    endtask

    task automatic exp_resp(input logic [XLEN-1:0] d, input logic err);
        resp_exp_t r;
        r.data  = d;
        r.error = err;
        resp_q.push_back(r);
    endtask

    // Bus responder and bus-side monitor
    int              wait_cnt = 0;
    logic            snap_ok  = 1'b0;
    logic [51:0]     snap;
    always @(negedge clk) begin
        bus_exp_t e;
        if (!rst_n) begin
            i_bus_ready = 1'b0;
            wait_cnt    = 0;
            snap_ok     = 1'b0;
        end else begin
            if (snap_ok) begin
                chk("bus_hold_valid", o_bus_valid, 1);
                chk("bus_hold_fields", {o_bus_access, o_bus_address,
                    o_bus_write_data, o_bus_strobe}, snap);
            end
            snap_ok = 1'b0;
            if (i_bus_ready) begin
                i_bus_ready = 1'b0;
                wait_cnt    = 0;
            end
            if (o_bus_valid) begin
                if (wait_cnt >= bus_delay) begin
                    i_bus_ready     = 1'b1;
                    i_bus_read_data = bus_rdata;
                    i_bus_status    = bus_stat;
                    chk("bus_txn_expected", bus_q.size() != 0, 1);
                    if (bus_q.size() != 0) begin
                        e = bus_q.pop_front();
                        chk("bus_access", o_bus_access,
                            e.write ? RGGEN_WRITE : RGGEN_READ);
                        chk("bus_address", o_bus_address, e.addr);
                        chk("bus_strobe", o_bus_strobe,
                            e.write ? 4'hF : 4'h0);
                        if (e.write)
                            chk("bus_wdata", o_bus_write_data, e.data);
                    end
                end else begin
                    wait_cnt++;
                    snap_ok = 1'b1;
                    snap = {o_bus_access, o_bus_address,
                            o_bus_write_data, o_bus_strobe};
                end
            end
        end
    end

    // Response monitor
    always @(negedge clk) begin
        resp_exp_t r;
        if (rst_n && o_resp_valid && i_resp_ready) begin
            chk("resp_expected", resp_q.size() != 0, 1);
            if (resp_q.size() != 0) begin
                r = resp_q.pop_front();
                chk("resp_data", o_resp_data, r.data);
                chk("resp_error", o_resp_error, r.error);
            end
        end
    end

    // Returns just after the accepting clock edge
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [XLEN-1:0] d, input logic nr,
                         input logic nw);
        int n = 0;
        while (!o_req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready_wait", o_req_ready, 1);
        i_req_valid    = 1'b1;
        i_req_op       = op;
        i_req_address  = a;
        i_req_data     = d;
        i_req_no_read  = nr;
        i_req_no_write = nw;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
    endtask

    // Cycles counted from the handshake cycle: accept cycle counts as 1
    task automatic wait_resp(input int exp_lat);
        int lat = -1;
        for (int k = 1; k <= 100; k++) begin
            if (o_resp_valid) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        chk("resp_latency", lat, exp_lat);
    endtask

    task automatic drain();
        logic done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (bus_q.size() == 0 && resp_q.size() == 0 && o_req_ready) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("drain_done", done, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        i_req_valid     = 1'b0;
        i_req_op        = 2'b00;
        i_req_address   = '0;
        i_req_data      = '0;
        i_req_no_read   = 1'b0;
        i_req_no_write  = 1'b0;
        i_resp_ready    = 1'b1;
        i_bus_ready     = 1'b0;
        i_bus_status    = RGGEN_OKAY;
        i_bus_read_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", o_req_ready, 1);
        chk("rst_bus_valid", o_bus_valid, 0);
        chk("rst_resp_valid", o_resp_valid, 0);
        chk("rst_resp_error", o_resp_error, 0);
        chk("rst_resp_data", o_resp_data, 0);
        chk("rst_bus_address", o_bus_address, 0);
        chk("rst_bus_wdata", o_bus_write_data, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // RS 0x300 |= 0x8 on 0x1800
        bus_rdata = 32'h1800;
        exp_bus(0, 14'hC00, '0);
        exp_bus(1, 14'hC00, 32'h1808);
        exp_resp(32'h1800, 0);
        issue(2'b10, 12'h300, 32'h8, 0, 0);
        wait_resp(3);
        drain();

        // RC 0x300 &= ~0x1800 on 0x1808
        bus_rdata = 32'h1808;
        exp_bus(0, 14'hC00, '0);
        exp_bus(1, 14'hC00, 32'h0008);
        exp_resp(32'h1808, 0);
        issue(2'b11, 12'h300, 32'h1800, 0, 0);
        wait_resp(3);
        drain();

        // RW with rd=x0: write only
        exp_bus(1, 14'hC14, 32'hA5);
        exp_resp(32'h0, 0);
        issue(2'b01, 12'h305, 32'hA5, 1, 0);
        wait_resp(2);
        drain();

        // RS with rs1=x0: read only
        bus_rdata = 32'hDEAD;
        exp_bus(0, 14'hD04, '0);
        exp_resp(32'hDEAD, 0);
        issue(2'b10, 12'h341, 32'h0, 0, 1);
        wait_resp(2);
        drain();

        // RW ignores no_write
        bus_rdata = 32'h5555;
        exp_bus(0, 14'hD00, '0);
        exp_bus(1, 14'hD00, 32'h1234);
        exp_resp(32'h5555, 0);
        issue(2'b01, 12'h340, 32'h1234, 0, 1);
        wait_resp(3);
        drain();

        // RC ignores no_read
        bus_rdata = 32'hFF;
        exp_bus(0, 14'h1F00, '0);
        exp_bus(1, 14'h1F00, 32'hF0);
        exp_resp(32'hFF, 0);
        issue(2'b11, 12'h7C0, 32'hF, 1, 0);
        wait_resp(3);
        drain();

        // Illegal op: no bus access
        exp_resp(32'h0, ERR_EN);
        issue(2'b00, 12'h123, 32'hFFFF, 0, 0);
        wait_resp(1);
        drain();

        // Bus stalls 5 cycles per access
        bus_delay = 5;
        bus_rdata = 32'h10;
        exp_bus(0, 14'hC00, '0);
        exp_bus(1, 14'hC00, 32'h11);
        exp_resp(32'h10, 0);
        issue(2'b10, 12'h300, 32'h1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            chk("stall_req_ready", o_req_ready, 0);
            chk("stall_bus_valid", o_bus_valid, 1);
            @(posedge clk); #1;
        end
        drain();
        bus_delay = 0;

        // Response held for 4 cycles, new request must wait
        i_resp_ready = 1'b0;
        bus_rdata = 32'h77;
        exp_bus(0, 14'hD00, '0);
        exp_bus(1, 14'hD00, 32'h11);
        exp_resp(32'h77, 0);
        issue(2'b01, 12'h340, 32'h11, 0, 0);
        wait_resp(3);
        for (int k = 0; k < 4; k++) begin
            chk("hold_resp_valid", o_resp_valid, 1);
            chk("hold_resp_data", o_resp_data, 32'h77);
            chk("hold_req_ready", o_req_ready, 0);
            i_req_valid   = 1'b1;
            i_req_op      = 2'b01;
            i_req_no_read = 1'b1;
            @(posedge clk); #1;
        end
        i_req_valid   = 1'b0;
        i_req_no_read = 1'b0;
        i_resp_ready  = 1'b1;
        drain();

        // Read with error status
        bus_stat  = RGGEN_SLAVE_ERROR;
        bus_rdata = 32'h10;
        exp_bus(0, 14'hC08, '0);
`ifdef RICE_CSR_ACCESS_ERROR_EN
        exp_resp(32'h0, 1);
        issue(2'b10, 12'h302, 32'h1, 0, 0);
        wait_resp(2);
`else
        exp_bus(1, 14'hC08, 32'h11);
        exp_resp(32'h10, 0);
        issue(2'b10, 12'h302, 32'h1, 0, 0);
        wait_resp(3);
`endif
        drain();
        bus_stat = RGGEN_OKAY;

        // Reset while in WRITE
        bus_delay = 20;
        exp_bus(1, 14'hC14, 32'h5A);
        issue(2'b01, 12'h305, 32'h5A, 1, 0);
        chk("pre_rst_bus_valid", o_bus_valid, 1);
        chk("pre_rst_bus_access", o_bus_access, RGGEN_WRITE);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_bus_valid", o_bus_valid, 0);
        chk("abort_resp_valid", o_resp_valid, 0);
        bus_q.delete();
        resp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus_delay = 0;
        @(posedge clk); #1;
        chk("post_rst_req_ready", o_req_ready, 1);
        chk("post_rst_bus_valid", o_bus_valid, 0);
        chk("post_rst_resp_valid", o_resp_valid, 0);

        // Recovery after reset
        bus_rdata = 32'h3;
        exp_bus(0, 14'hC00, '0);
        exp_bus(1, 14'hC00, 32'h7);
        exp_resp(32'h3, 0);
        issue(2'b10, 12'h300, 32'h4, 0, 0);
        wait_resp(3);
        drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
